// File: rtl/m68k_ram_ctrl_pkg.sv
// Shared definitions for the 68k work-RAM controller: FSM encoding and wait-state limits.
// Imported by the top module; it holds no logic of its own.
package m68k_ram_pkg;

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_ACK  = 2'd3;

    localparam int WAIT_MAX = 15;
    localparam int WCNT_W   = 4;

endpackage

// File: rtl/m68k_ram_ctrl_if.sv
// 68k-side bus bundle. Names are taken from the controller's point of view.
// The slave modport is used by the RAM controller and the master modport by the CPU or the bench.
interface m68k_ram_ctrl_if #(
    parameter int ADDR_W = 15,
    parameter int LANES  = 2
);
    logic [ADDR_W-1:0]  i_addr;
    logic [8*LANES-1:0] i_din;
    logic [8*LANES-1:0] o_dout;
    logic               i_nas;
    logic [LANES-1:0]   i_nlane;
    logic               i_rw;
    logic               o_ndtack;
    logic               o_busy;
    logic               o_err_nolane;
    logic               o_err_abort;

    modport slave (
        input  i_addr, i_din, i_nas, i_nlane, i_rw,
        output o_dout, o_ndtack, o_busy, o_err_nolane, o_err_abort
    );

    modport master (
        output i_addr, i_din, i_nas, i_nlane, i_rw,
        input  o_dout, o_ndtack, o_busy, o_err_nolane, o_err_abort
    );
endinterface

// File: rtl/m68k_ram_ctrl_ram_bytelane.sv
// One byte lane: a single-port 8-bit x 2**ADDR_W synchronous RAM with a registered read.
// Read-during-write returns the old data. This module applies no backpressure.
module ram_bytelane #(
    parameter int ADDR_W = 15
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_wdat,
    output logic [7:0]        o_rdat
);
    logic [7:0] r_mem [0:(2**ADDR_W)-1];
    logic [7:0] r_rdat;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdat;
        end
        r_rdat <= r_mem[i_addr];
    end

    assign o_rdat = r_rdat;
endmodule

// File: rtl/m68k_ram_ctrl.sv
// 68k work-RAM controller: zero-fill after reset, then strobe-decoded accesses with nDTACK.
// An access and the fall of nDTACK occur WAIT_STATES+1 edges after capture; the master is held off via nDTACK and BUSY.
import m68k_ram_pkg::*;

module m68k_ram_ctrl #(
    parameter int ADDR_W      = 15,
    parameter int LANES       = 2,
    parameter int WAIT_STATES = 2,
    parameter int INIT_ZERO   = 1
) (
    input logic            i_clk,
    input logic            i_rst,
    m68k_ram_ctrl_if.slave bus
);
    localparam int DW = 8 * LANES;
    localparam int WS_CLAMP = (WAIT_STATES > WAIT_MAX) ? WAIT_MAX : WAIT_STATES;
    localparam logic [WCNT_W-1:0] WS_LOAD = WCNT_W'(WS_CLAMP);
    localparam logic [1:0] RST_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_IDLE;
    localparam logic RST_BUSY = (INIT_ZERO != 0);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_fill_cnt;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [LANES-1:0]  r_nlane;
    logic              r_rw;
    logic [DW-1:0]     r_dout;
    logic              r_ndtack;
    logic              r_busy;
    logic              r_err_nolane;
    logic              r_err_abort;
    logic              r_nolane_hold;

    logic              w_fill;
    logic              w_strobe_any;
    logic              w_access;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [LANES-1:0]  w_lane_we;
    logic [DW-1:0]     w_lane_wdat;
    logic [DW-1:0]     w_rd_data;
    logic [DW-1:0]     w_rd_masked;

    assign w_fill       = (r_state == ST_INIT);
    assign w_strobe_any = ~&bus.i_nlane;
    assign w_access     = (r_state == ST_WAIT) && !bus.i_nas && (r_wait_cnt == '0);

    // In IDLE the live address feeds the RAM, so the read data is already registered when a zero-wait access completes.
    assign w_ram_addr  = w_fill ? r_fill_cnt : ((r_state == ST_IDLE) ? bus.i_addr : r_addr);
    assign w_lane_wdat = w_fill ? '0 : bus.i_din;

    always_comb begin
        w_lane_we   = '0;
        w_rd_masked = '0;
        for (int i = 0; i < LANES; i++) begin
            w_lane_we[i]        = w_fill | (w_access & ~r_rw & ~r_nlane[i]);
            w_rd_masked[8*i +: 8] = r_nlane[i] ? 8'h00 : w_rd_data[8*i +: 8];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        ram_bytelane #(.ADDR_W(ADDR_W)) u_ram (
            .i_clk  (i_clk),
            .i_we   (w_lane_we[g]),
            .i_addr (w_ram_addr),
            .i_wdat (w_lane_wdat[8*g +: 8]),
            .o_rdat (w_rd_data[8*g +: 8])
        );
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= RST_STATE;
            r_fill_cnt    <= '0;
            r_wait_cnt    <= '0;
            r_addr        <= '0;
            r_nlane       <= '1;
            r_rw          <= 1'b1;
            r_dout        <= '0;
            r_ndtack      <= 1'b1;
            r_busy        <= RST_BUSY;
            r_err_nolane  <= 1'b0;
            r_err_abort   <= 1'b0;
            r_nolane_hold <= 1'b0;
        end else begin
            r_err_nolane <= 1'b0;
            r_err_abort  <= 1'b0;
            if (bus.i_nas) begin
                r_nolane_hold <= 1'b0;
            end
            case (r_state)
                ST_INIT: begin
                    r_fill_cnt <= r_fill_cnt + 1'b1;
                    if (&r_fill_cnt) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (!bus.i_nas) begin
                        if (w_strobe_any) begin
                            r_addr     <= bus.i_addr;
                            r_nlane    <= bus.i_nlane;
                            r_rw       <= bus.i_rw;
                            r_wait_cnt <= WS_LOAD;
                            r_state    <= ST_WAIT;
                        end else if (!r_nolane_hold) begin
                            // One pulse per strobe assertion, re-armed only once nAS goes high.
                            r_err_nolane  <= 1'b1;
                            r_nolane_hold <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.i_nas) begin
                        r_err_abort <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else if (r_wait_cnt != '0) begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end else begin
                        r_ndtack <= 1'b0;
                        r_state  <= ST_ACK;
                        if (r_rw) begin
                            r_dout <= w_rd_masked;
                        end
                    end
                end
                ST_ACK: begin
                    if (bus.i_nas) begin
                        r_ndtack <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_dout       = r_dout;
    assign bus.o_ndtack     = r_ndtack;
    assign bus.o_busy       = r_busy;
    assign bus.o_err_nolane = r_err_nolane;
    assign bus.o_err_abort  = r_err_abort;
endmodule

// File: tb/tb_m68k_ram_ctrl.sv
// Bench for m68k_ram_ctrl: a memory model feeds a read-data scoreboard, and the bench checks latency, errors and zero-fill.
module tb_m68k_ram_ctrl;
    localparam int AW    = 5;
    localparam int LN    = 2;
    localparam int WS    = 2;
    localparam int DEPTH = 2 ** AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    m68k_ram_ctrl_if #(.ADDR_W(AW), .LANES(LN)) bus ();

    m68k_ram_ctrl #(
        .ADDR_W      (AW),
        .LANES       (LN),
        .WAIT_STATES (WS),
        .INIT_ZERO   (1)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] model [DEPTH];
    logic [15:0] sb_q [$];
    logic [15:0] last_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lane_mask(input logic [1:0] nl);
        return {{8{~nl[1]}}, {8{~nl[0]}}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.i_nas   = 1'b1;
        bus.i_nlane = 2'b11;
        bus.i_rw    = 1'b1;
        bus.i_addr  = '0;
        bus.i_din   = '0;
    endtask

    // A nonzero cut re-asserts reset after that many fill edges.
    task automatic reset_and_fill(input int cut);
        int   n;
        logic dt_low;
        bus_idle();
        rst = 1'b1;
        tick();
        chk("rst_busy", bus.o_busy, 1);
        chk("rst_dtack", bus.o_ndtack, 1);
        chk("rst_dout", bus.o_dout, 0);
        chk("rst_err_nolane", bus.o_err_nolane, 0);
        chk("rst_err_abort", bus.o_err_abort, 0);
        rst = 1'b0;
        if (cut > 0) begin
            repeat (cut) @(posedge clk);
            #1;
            chk("busy_mid_fill", bus.o_busy, 1);
            rst = 1'b1;
            tick();
            rst = 1'b0;
        end
        n = 0;
        dt_low = 1'b0;
        while (bus.o_busy && n < DEPTH + 10) begin
            tick();
            n++;
            if (!bus.o_ndtack) dt_low = 1'b1;
        end
        chk("fill_len", n, DEPTH);
        chk("fill_dtack", dt_low, 0);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        last_rd = '0;
    endtask

    task automatic access(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] nl, input logic rw);
        int          n;
        logic [15:0] m;
        logic [15:0] exp;
        m = lane_mask(nl);
        bus.i_addr  = a;
        bus.i_nlane = nl;
        bus.i_rw    = rw;
        bus.i_din   = ~d;
        bus.i_nas   = 1'b0;
        if (rw) sb_q.push_back(model[a] & m);
        tick();
        // After capture, the address and lanes are scrambled and the real write data is presented.
        bus.i_addr  = ~a;
        bus.i_nlane = ~nl;
        bus.i_din   = d;
        n = 0;
        while (bus.o_ndtack && n < 20) begin
            tick();
            n++;
        end
        chk(rw ? "rd_latency" : "wr_latency", n, WS + 1);
        if (rw) begin
            exp = sb_q.pop_front();
            chk("rd_data", bus.o_dout, exp);
            last_rd = exp;
        end else begin
            chk("wr_dout_hold", bus.o_dout, last_rd);
            model[a] = (model[a] & ~m) | (d & m);
        end
        bus.i_nas = 1'b1;
        tick();
        chk("dtack_release", bus.o_ndtack, 1);
        bus_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int cnt;
        reset_and_fill(0);
        access(5'h07, 16'h0000, 2'b00, 1'b1);

        access(5'h12, 16'hBEEF, 2'b00, 1'b0);
        access(5'h12, 16'h0000, 2'b00, 1'b1);
        access(5'h12, 16'h0000, 2'b01, 1'b1);

        access(5'h03, 16'h55AA, 2'b01, 1'b0);
        access(5'h03, 16'h0000, 2'b00, 1'b1);
        access(5'h03, 16'h0000, 2'b10, 1'b1);

        // Abort: nAS drops for the capture edge only.
        bus.i_addr  = 5'h12;
        bus.i_din   = 16'hDEAD;
        bus.i_nlane = 2'b00;
        bus.i_rw    = 1'b0;
        bus.i_nas   = 1'b0;
        tick();
        chk("abort_pre", bus.o_err_abort, 0);
        bus.i_nas = 1'b1;
        tick();
        chk("abort_pulse", bus.o_err_abort, 1);
        chk("abort_dtack", bus.o_ndtack, 1);
        tick();
        chk("abort_pulse_end", bus.o_err_abort, 0);
        chk("abort_dtack2", bus.o_ndtack, 1);
        bus_idle();
        access(5'h12, 16'h0000, 2'b00, 1'b1);

        // nAS held low with no lane strobes for five cycles.
        bus.i_nas   = 1'b0;
        bus.i_nlane = 2'b11;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.o_err_nolane) cnt++;
        end
        chk("nolane_pulses", cnt, 1);
        chk("nolane_dtack", bus.o_ndtack, 1);
        bus_idle();
        tick();
        chk("nolane_end", bus.o_err_nolane, 0);
        access(5'h03, 16'h0000, 2'b00, 1'b1);

        // Dirty the array, interrupt a fill at counter 9, then confirm the restarted fill clears everything.
        access(5'h05, 16'h1234, 2'b00, 1'b0);
        access(5'h1F, 16'hA5C3, 2'b00, 1'b0);
        access(5'h1F, 16'h0000, 2'b00, 1'b1);
        reset_and_fill(9);
        access(5'h05, 16'h0000, 2'b00, 1'b1);
        access(5'h1F, 16'h0000, 2'b00, 1'b1);
        access(5'h12, 16'h0000, 2'b00, 1'b1);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/m68k_ram_ctrl.md
# m68k_ram_ctrl

Synchronous, parametrised 68000-side work-RAM block for the NeoGeo FPGA build. It replaces the per-byte asynchronous RAM models with one clocked controller that:
- owns N byte-lane RAM banks;
- decodes 68k-style strobes and inserts a programmable number of wait states;
- generates nDTACK and flags bus-protocol errors.

After reset it zero-fills the whole array in hardware before serving any access.

## Interface
- ADDR_W, 15: word address width; depth = 2**ADDR_W words.
- LANES, 2: byte lanes per word; data width = 8*LANES (lane 0 = bits 7:0).
- WAIT_STATES, 2: CLK cycles inserted before the access edge; legal range 0..15.
- INIT_ZERO, 1: 1 = hardware zero-fill after reset; 0 = skip the fill, RAM contents undefined.
- CLK  in  1  system clock; single clock domain.
- RESET  in  1  asynchronous, active-high reset.
- ADDR  in  ADDR_W  word address.
- DIN  in  8*LANES  write data.
- DOUT  out  8*LANES  registered read data.
- nAS  in  1  address strobe, active low.
- nLANE  in  LANES  per-lane data strobes, active low; nLDS/nUDS equivalent.
- RW  in  1  1 = read, 0 = write.
- nDTACK  out  1  transfer acknowledge, active low, registered.
- BUSY  out  1  high while zero-fill runs.
- ERR_NOLANE  out  1  one-cycle pulse: nAS low with all nLANE high.
- ERR_ABORT  out  1  one-cycle pulse: nAS released before acknowledge.

## Operation
- All inputs are synchronous to CLK. No synchronisers are inside the block.
- States: INIT, IDLE, WAIT, ACK.
- **Reset values:**
  - state = INIT if INIT_ZERO=1, otherwise IDLE;
  - fill counter = 0, wait counter = 0;
  - nDTACK = 1, DOUT = 0, BUSY = INIT_ZERO, ERR_* = 0.
- **INIT:**
  - Each cycle writes 0 to every lane at the fill-counter address, then increments the counter.
  - After writing address 2**ADDR_W-1, go to IDLE and drop BUSY.
  - Bus strobes are ignored. An access pending at the end of the fill is taken on the first IDLE cycle.
- **IDLE:**
  - nAS low and at least one nLANE low: capture ADDR, nLANE and RW; load the wait counter with WAIT_STATES; go to WAIT.
  - nAS low and all nLANE high: pulse ERR_NOLANE and stay in IDLE. No further pulse until nAS has gone high again.
- **WAIT:**
  - nAS high (abort): pulse ERR_ABORT and go to IDLE with no memory change. Abort has priority over the access.
  - Otherwise, if the counter is nonzero, decrement it.
  - If the counter is 0, perform the access and go to ACK with nDTACK = 0.
- **Access:**
  - Read: DOUT lane i = mem lane i if that lane's strobe was captured low, else 0.
  - Write: DIN is sampled on the access edge, not at capture. Only the captured lanes are written. DOUT is unchanged.
- **ACK:**
  - Hold nDTACK = 0 while nAS is low.
  - On the first edge with nAS high: nDTACK = 1, go to IDLE.
  - A new access needs nAS low again in IDLE, so back-to-back accesses need one nAS-high cycle.
- DOUT holds its last read value until the next read completes.
- Address and lane changes after capture are ignored until the next IDLE capture.

## Timing
- nAS low first sampled at edge N in IDLE: access and nDTACK fall both occur at edge N+1+WAIT_STATES. DOUT is valid at that same edge.
- nAS high sampled at edge M in ACK: nDTACK = 1 after edge M. The earliest next capture is edge M+1.
- Zero-fill takes exactly 2**ADDR_W cycles. BUSY falls on the edge that writes the last address.
- ERR pulses are exactly one cycle wide and registered.
- RESET asserted mid-access or mid-fill:
  - immediate return to reset values;
  - a partially completed fill restarts from 0;
  - no write is performed for an in-flight WAIT.

## Structure
- Package m68k_ram_pkg holds:
  - the state encoding (INIT/IDLE/WAIT/ACK);
  - the WAIT_STATES range limit of 15 and the 4-bit wait-counter width.
- Sub-module ram_bytelane: a single-port synchronous 8-bit x 2**ADDR_W RAM with write enable and registered read. It is instantiated LANES times via generate.
- The fill and access write ports are muxed ahead of each lane bank.

## Test plan
- Reset with INIT_ZERO=1, ADDR_W=4: BUSY high for 16 cycles, nDTACK stays 1 throughout; read of address 0x7 afterwards returns 0x0000.
- WAIT_STATES=2: write 0xBEEF to 0x12 with both lanes, then read it. nDTACK falls 3 edges after the nAS capture and DOUT = 0xBEEF.
- Lane masking: write 0x55AA to 0x3 with only lane 1 low over prior 0x0000. A full read returns 0x5500; a lane-0-only read returns 0x0000.
- Abort: nAS low at edge N, high at N+1 with WAIT_STATES=3. ERR_ABORT pulses once, nDTACK never falls, memory is unchanged.
- No-lane strobe: nAS low with nLANE=2'b11 for 5 cycles. Exactly one ERR_NOLANE pulse, state stays IDLE.
- RESET pulsed during fill at counter 9: fill restarts at 0, BUSY stays high for a full 2**ADDR_W cycles from release.
